// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serializer among four requesters.
// Grants one byte, strobes tx_start, holds the byte for a full frame, then waits a guard gap.
module uart_tx_arbiter #(
  parameter int FRAME_CYCLES = 104245,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  typedef enum logic [2:0] {SETTLE, IDLE, START, HOLD, GAP} state_t;

  localparam logic [16:0] SETTLE_LAST = 17'd1;
  localparam logic [16:0] FRAME_LAST  = 17'(FRAME_CYCLES - 1);
  localparam logic [16:0] GAP_LAST    = 17'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [3:0]  ack_q, ack_d;

  logic        found;
  logic [1:0]  winner;
  logic [1:0]  probe;

  // Search begins just after the last served requester and wraps ascending.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    probe  = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      probe = last_grant_q + 2'(k);
      if (!found && req[probe]) begin
        found  = 1'b1;
        winner = probe;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 17'd1;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    ack_d        = 4'b0000;
    case (state_q)
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = IDLE;
          cnt_d   = 17'd0;
        end
      end
      IDLE: begin
        cnt_d = 17'd0;
        if (found) begin
          state_d    = START;
          grant_id_d = winner;
          tx_data_d  = req_data[{winner, 3'b000} +: 8];
          ack_d      = 4'b0001 << winner;
        end
      end
      START: begin
        state_d = HOLD;
        cnt_d   = 17'd0;
      end
      HOLD: begin
        if (cnt_q == FRAME_LAST) begin
          state_d = GAP;
          cnt_d   = 17'd0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d      = IDLE;
          cnt_d        = 17'd0;
          last_grant_d = grant_id_q;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = 17'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      cnt_q        <= 17'd0;
      last_grant_q <= 2'd3;
      grant_id_q   <= 2'd0;
      tx_data_q    <= 8'h00;
      ack_q        <= 4'b0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      ack_q        <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == START);
  assign busy     = (state_q == START) || (state_q == HOLD) || (state_q == GAP);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int FRAME  = 20;
  localparam int GAP    = 2;
  localparam int PERIOD = 1 + FRAME + GAP + 1;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;

  int checks = 0;
  int fails  = 0;

  uart_tx_arbiter #(.FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .tx_start(tx_start),
    .tx_data(tx_data)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] i;
    for (int k = 1; k <= 4; k++) begin
      i = last + 2'(k);
      if (r[i]) return i;
    end
    return last;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] i);
    return d[8*i +: 8];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!tx_start && n <= limit);
  endtask

  task automatic test_reset();
    int n;
    rst_n    = 1'b0;
    req      = 4'hF;
    req_data = $urandom;
    repeat (4) @(negedge sys_clk);
    checks++;
    if ({ack, grant_id, busy, tx_start, tx_data} !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0000", {ack, grant_id, busy, tx_start, tx_data});
    end
    rst_n = 1'b1;
    wait_start(10, n);
    checks++;
    if (n !== 3 || tx_start !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_start: got %0d clocks expected 3", n);
    end
    checks++;
    if (grant_id !== 2'd0 || ack !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL first_grant: got id %0d ack %b expected 0 0001", grant_id, ack);
    end
    checks++;
    if (tx_data !== req_data[7:0]) begin
      fails++;
      $display("[TB] FAIL first_data: got %h expected %h", tx_data, req_data[7:0]);
    end
  endtask

  task automatic test_single();
    int n, busy_cnt, data_bad, extra;
    do_reset();
    req_data = $urandom;
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    wait_start(10, n);
    checks++;
    if (tx_start !== 1'b1 || ack !== 4'b0100 || grant_id !== 2'd2 || tx_data !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL single_grant: got start %b ack %b id %0d data %h expected 1 0100 2 a5",
               tx_start, ack, grant_id, tx_data);
    end
    req = 4'b0000;
    busy_cnt = busy ? 1 : 0;
    data_bad = 0;
    extra    = 0;
    for (int i = 1; i < 40; i++) begin
      @(negedge sys_clk);
      if (busy === 1'b1) busy_cnt++;
      if (i < 24 && tx_data !== 8'hA5) data_bad++;
      if (tx_start !== 1'b0 || ack !== 4'b0000) extra++;
    end
    checks++;
    if (busy_cnt !== 23) begin
      fails++;
      $display("[TB] FAIL single_busy: got %0d cycles expected 23", busy_cnt);
    end
    checks++;
    if (data_bad !== 0) begin
      fails++;
      $display("[TB] FAIL single_hold: got %0d unstable cycles expected 0", data_bad);
    end
    checks++;
    if (extra !== 0) begin
      fails++;
      $display("[TB] FAIL single_extra: got %0d stray strobes expected 0", extra);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] last, exp_id;
    do_reset();
    req_data = 32'h43322110;
    req  = 4'hF;
    last = 2'd3;
    for (int k = 0; k < 5; k++) begin
      wait_start(PERIOD + 5, n);
      exp_id = rr_pick(4'hF, last);
      checks++;
      if (tx_start !== 1'b1 || grant_id !== exp_id) begin
        fails++;
        $display("[TB] FAIL rr_grant: got %0d expected %0d (round %0d)", grant_id, exp_id, k);
      end
      checks++;
      if (tx_data !== byte_of(req_data, exp_id) || ack !== (4'b0001 << exp_id)) begin
        fails++;
        $display("[TB] FAIL rr_data: got %h/%b expected %h/%b", tx_data, ack,
                 byte_of(req_data, exp_id), 4'b0001 << exp_id);
      end
      checks++;
      if (n !== ((k == 0) ? 3 : PERIOD)) begin
        fails++;
        $display("[TB] FAIL rr_period: got %0d expected %0d", n, (k == 0) ? 3 : PERIOD);
      end
      last = exp_id;
    end
    req = 4'b0000;
  endtask

  task automatic test_late_arrival();
    int n;
    do_reset();
    req_data = $urandom;
    req = 4'b0001;
    wait_start(10, n);
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0) begin
      fails++;
      $display("[TB] FAIL late_first: got %0d expected 0", grant_id);
    end
    repeat (8) @(negedge sys_clk);
    req[3] = 1'b1;
    wait_start(PERIOD, n);
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 2'd3 || n !== PERIOD - 8) begin
      fails++;
      $display("[TB] FAIL late_second: got id %0d after %0d expected 3 after %0d", grant_id, n, PERIOD - 8);
    end
    checks++;
    if (ack !== 4'b1000 || tx_data !== req_data[31:24]) begin
      fails++;
      $display("[TB] FAIL late_data: got %b/%h expected 1000/%h", ack, tx_data, req_data[31:24]);
    end
    req[3] = 1'b0;
    wait_start(PERIOD + 2, n);
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0 || n !== PERIOD) begin
      fails++;
      $display("[TB] FAIL late_third: got id %0d after %0d expected 0 after %0d", grant_id, n, PERIOD);
    end
    req = 4'b0000;
  endtask

  task automatic test_withdrawn();
    int n, ack1, starts;
    do_reset();
    req_data = $urandom;
    req = 4'b0001;
    wait_start(10, n);
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 2'd0) begin
      fails++;
      $display("[TB] FAIL wd_first: got %0d expected 0", grant_id);
    end
    req = 4'b0000;
    ack1 = 0;
    starts = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      if (i == 5) req[1] = 1'b1;
      if (i == 9) req[1] = 1'b0;
      @(negedge sys_clk);
      if (ack[1] === 1'b1) ack1++;
      if (tx_start === 1'b1) starts++;
    end
    checks++;
    if (ack1 !== 0 || starts !== 0) begin
      fails++;
      $display("[TB] FAIL wd_served: got %0d acks %0d starts expected 0 0", ack1, starts);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n;
    do_reset();
    req_data = $urandom;
    req = 4'b0010;
    wait_start(10, n);
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 2'd1) begin
      fails++;
      $display("[TB] FAIL mid_first: got %0d expected 1", grant_id);
    end
    req = 4'b0100;
    repeat (11) @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({ack, grant_id, busy, tx_start, tx_data} !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL mid_reset: got %h expected 0000", {ack, grant_id, busy, tx_start, tx_data});
    end
    rst_n = 1'b1;
    wait_start(10, n);
    checks++;
    if (tx_start !== 1'b1 || n !== 3 || grant_id !== 2'd2 || ack !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL mid_resume: got id %0d after %0d ack %b expected 2 after 3 ack 0100",
               grant_id, n, ack);
    end
    checks++;
    if (tx_data !== req_data[23:16]) begin
      fails++;
      $display("[TB] FAIL mid_data: got %h expected %h", tx_data, req_data[23:16]);
    end
    req = 4'b0000;
  endtask

  // Randomized traffic: a start is due whenever the arbiter has been free long
  // enough and someone was requesting at the sampling edge.
  task automatic test_random();
    int since, need, frame_age;
    logic started;
    logic [3:0] req_seen;
    logic [1:0] last, exp_id;
    logic [7:0] cur_byte;
    logic exp_start, exp_busy;
    do_reset();
    req_data = $urandom;
    since = 0;
    need = 3;
    last = 2'd3;
    started = 1'b0;
    frame_age = 0;
    cur_byte = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      @(negedge sys_clk);
      since++;
      frame_age++;
      req_seen  = req;
      exp_start = (since >= need) && (req_seen != 4'b0000);
      checks++;
      if (tx_start !== exp_start) begin
        fails++;
        $display("[TB] FAIL rnd_start: got %b expected %b at cycle %0d", tx_start, exp_start, c);
      end
      if (exp_start) begin
        exp_id   = rr_pick(req_seen, last);
        cur_byte = byte_of(req_data, exp_id);
        checks++;
        if (grant_id !== exp_id || ack !== (4'b0001 << exp_id) || tx_data !== cur_byte) begin
          fails++;
          $display("[TB] FAIL rnd_grant: got %0d/%b/%h expected %0d/%b/%h", grant_id, ack, tx_data,
                   exp_id, 4'b0001 << exp_id, cur_byte);
        end
        last = exp_id;
        since = 0;
        need = PERIOD;
        started = 1'b1;
        frame_age = 0;
        req[exp_id] = 1'b0;
      end else begin
        checks++;
        if (ack !== 4'b0000 || (started && tx_data !== cur_byte)) begin
          fails++;
          $display("[TB] FAIL rnd_idle: got ack %b data %h expected 0000 %h", ack, tx_data, cur_byte);
        end
      end
      exp_busy = started && (frame_age < PERIOD - 1);
      checks++;
      if (busy !== exp_busy) begin
        fails++;
        $display("[TB] FAIL rnd_busy: got %b expected %b at cycle %0d", busy, exp_busy, c);
      end
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 29) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    $display("[TB] starting uart_tx_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_late_arrival();
    test_withdrawn();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
